// File: rtl/ddr3_pg_arb_pkg.sv
// Shared types and constants for the DDR3 page-transfer arbiter.
package ddr3_pg_arb_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned IDX_W  = 2;

  localparam int unsigned IDX_HBUF  = 0;
  localparam int unsigned IDX_XDOM  = 1;
  localparam int unsigned IDX_SPARE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request strictly after last_idx, wrapping.
module rr_pick
  import ddr3_pg_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [2:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = 3'(last_idx) + 3'(k);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!valid && cand == 3'(j) && req[j]) begin
          valid = 1'b1;
          idx   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_pg_arbiter.sv
// Round-robin arbiter granting DDR3 page-engine access to N_REQ requesters.
// Optional release watchdog enabled by defining DDR3_PG_ARB_TIMEOUT_EN.
module ddr3_pg_arbiter
  import ddr3_pg_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        optype,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] dpram_dout,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        dpram_wren,
  output logic                    ddr3_pg_req,
  output logic                    ddr3_pg_optype,
  output logic [ADDR_W-1:0]       ddr3_pg_req_addr,
  output logic [DATA_W-1:0]       ddr3_dpram_dout,
  input  logic                    ddr3_pg_ack,
  input  logic                    ddr3_dpram_wren,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    timeout_err,
  output logic [IDX_W-1:0]        timeout_idx
);

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ddr3_pg_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
  end

  state_t             state;
  logic [N_REQ-1:0]   req_m;
  logic [N_REQ-1:0]   req_s;
  logic [N_REQ-1:0]   mask;
  logic [IDX_W-1:0]   last_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               gnt_req_s;
  logic               clear_exit;

  // Requests come from other clock domains.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_m <= '0;
      req_s <= '0;
    end else begin
      req_m <= req;
      req_s <= req_m;
    end
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req_s & ~mask),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Payload mux and ack/wren steering; unmatched grant_idx yields zeros.
  always_comb begin
    ddr3_pg_optype   = 1'b0;
    ddr3_pg_req_addr = '0;
    ddr3_dpram_dout  = '0;
    ack              = '0;
    dpram_wren       = '0;
    gnt_req_s        = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        ddr3_pg_optype   = optype[i];
        ddr3_pg_req_addr = req_addr[i*ADDR_W +: ADDR_W];
        ddr3_dpram_dout  = dpram_dout[i*DATA_W +: DATA_W];
        gnt_req_s        = req_s[i];
        ack[i]           = ddr3_pg_ack && (state != ST_IDLE);
        dpram_wren[i]    = ddr3_dpram_wren && (state != ST_IDLE);
      end
    end
  end

  assign clear_exit = (state == ST_CLEAR) && !gnt_req_s && !ddr3_pg_ack;

`ifdef DDR3_PG_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd;
  logic            timeout_hit;

  assign timeout_hit = (state == ST_CLEAR) && (wd == WD_W'(TIMEOUT_CYCLES - 1)) && !clear_exit;

  // Watchdog on requesters that never release; the offender stays masked until it drops req.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd          <= '0;
      mask        <= '0;
      timeout_err <= 1'b0;
      timeout_idx <= '0;
    end else begin
      wd <= (state == ST_CLEAR) ? wd + WD_W'(1) : '0;
      if (timeout_hit) begin
        timeout_err <= 1'b1;
        timeout_idx <= grant_idx;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        mask[i] <= (timeout_hit && grant_idx == IDX_W'(i)) || (mask[i] && req_s[i]);
      end
    end
  end
`else
  assign mask        = '0;
  assign timeout_err = 1'b0;
  assign timeout_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ddr3_pg_req <= 1'b0;
      grant_idx   <= IDX_W'(IDX_HBUF);
      last_idx    <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          ddr3_pg_req <= 1'b0;
          if (pick_valid) begin
            grant_idx   <= pick_idx;
            ddr3_pg_req <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          ddr3_pg_req <= 1'b1;
          if (ddr3_pg_ack) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          // Follow the requester's release; leave once both sides have let go.
          ddr3_pg_req <= gnt_req_s;
          if (clear_exit) begin
            last_idx <= grant_idx;
            state    <= ST_IDLE;
          end
`ifdef DDR3_PG_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            ddr3_pg_req <= 1'b0;
            state       <= ST_FLUSH;
          end
`endif
        end
        ST_FLUSH: begin
          ddr3_pg_req <= 1'b0;
          if (!ddr3_pg_ack) begin
            last_idx <= grant_idx;
            state    <= ST_IDLE;
          end
        end
        default: begin
          ddr3_pg_req <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pg_arbiter.sv
// Self-checking bench for ddr3_pg_arbiter: reset table, directed sequences, random round-robin traffic.
module tb_ddr3_pg_arbiter;

  localparam int N = 3;

  logic           clk;
  logic           rst;
  logic [2:0]     req;
  logic [2:0]     tb_opt;
  logic [27:0]    tb_addr [N];
  logic [127:0]   tb_data [N];
  logic [N*28-1:0]  req_addr;
  logic [N*128-1:0] dpram_dout;
  logic [2:0]     ack;
  logic [2:0]     dpram_wren;
  logic           ddr3_pg_req;
  logic           ddr3_pg_optype;
  logic [27:0]    ddr3_pg_req_addr;
  logic [127:0]   ddr3_dpram_dout;
  logic           ddr3_pg_ack;
  logic           ddr3_dpram_wren;
  logic [1:0]     grant_idx;
  logic           timeout_err;
  logic [1:0]     timeout_idx;

  int n_chk = 0;
  int n_err = 0;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_addr[i*28 +: 28]    = tb_addr[i];
    assign dpram_dout[i*128 +: 128] = tb_data[i];
  end

  ddr3_pg_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .optype           (tb_opt),
    .req_addr         (req_addr),
    .dpram_dout       (dpram_dout),
    .ack              (ack),
    .dpram_wren       (dpram_wren),
    .ddr3_pg_req      (ddr3_pg_req),
    .ddr3_pg_optype   (ddr3_pg_optype),
    .ddr3_pg_req_addr (ddr3_pg_req_addr),
    .ddr3_dpram_dout  (ddr3_dpram_dout),
    .ddr3_pg_ack      (ddr3_pg_ack),
    .ddr3_dpram_wren  (ddr3_dpram_wren),
    .grant_idx        (grant_idx),
    .timeout_err      (timeout_err),
    .timeout_idx      (timeout_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int i);
    return 3'(1 << i);
  endfunction

  // Reference rule: first pending requester strictly after the last served one, wrapping.
  function automatic int rr_next(input logic [2:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ddr3_pg_ack = 1'b0;
    ddr3_dpram_wren = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    while (ddr3_pg_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Page engine: wait for the request, ack after dly cycles, pulse wren nw cycles,
  // hold ack until ddr3_pg_req drops. The granted requester releases on ack.
  task automatic serve(input int g, input int dly, input int nw, input logic [2:0] raise,
                       output int rise_n);
    int m;
    wait_rise(rise_n);
    chk("pg_req_rise", ddr3_pg_req, 1'b1);
    if (ddr3_pg_req !== 1'b1) return;
    // ack held until fall leaves one extra IDLE cycle: at least two low samples.
    chk("pg_req_gap", 128'(rise_n >= 2), 1);
    chk("grant_idx", grant_idx, g);
    req = req | raise;
    for (int j = 0; j < N; j++) begin
      if (j != g) begin
        tb_addr[j] = 28'($urandom);
        tb_data[j] = {$urandom, $urandom, $urandom, $urandom};
        tb_opt[j]  = 1'($urandom_range(0, 1));
      end
    end
    #1;
    chk("mux_optype", ddr3_pg_optype, tb_opt[g]);
    chk("mux_addr", ddr3_pg_req_addr, tb_addr[g]);
    chk("mux_dout", ddr3_dpram_dout, tb_data[g]);
    repeat (dly) begin
      tick();
      chk("pg_req_hold", ddr3_pg_req, 1'b1);
      chk("ack_early", ack, 3'b000);
    end
    ddr3_pg_ack = 1'b1;
    req[g] = 1'b0;
    #1;
    chk("ack_onehot", ack, oh(g));
    for (int k = 0; k < nw; k++) begin
      ddr3_dpram_wren = 1'b1;
      #1;
      chk("wren_on", dpram_wren, oh(g));
      tick();
    end
    ddr3_dpram_wren = 1'b0;
    #1;
    chk("wren_off", dpram_wren, 3'b000);
    m = 0;
    while (ddr3_pg_req !== 1'b0 && m < 40) begin
      chk("ack_mirror", ack, oh(g));
      tick();
      m++;
    end
    chk("pg_req_fall", ddr3_pg_req, 1'b0);
    ddr3_pg_ack = 1'b0;
    #1;
    chk("ack_release", ack, 3'b000);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] opt;
    logic       pg_ack;
    logic       pg_wren;
    logic [2:0] e_ack;
    logic [2:0] e_wren;
    logic       e_pg_req;
    logic       e_opt;
  } vec_t;

  vec_t vt [6];

  initial begin
    int n;
    int exp_g;
    int last;
    int dly;
    int nw;
    logic [2:0] pend;
    logic [2:0] raise;
    int waits [N];

    vt[0] = '{1'b1, 3'b111, 3'b101, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1};
    vt[1] = '{1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[2] = '{1'b1, 3'b000, 3'b111, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1};
    vt[3] = '{1'b0, 3'b000, 3'b011, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1};
    vt[4] = '{1'b0, 3'b000, 3'b110, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
    vt[5] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};

    rst = 1'b1;
    req = '0;
    tb_opt = '0;
    ddr3_pg_ack = 1'b0;
    ddr3_dpram_wren = 1'b0;
    for (int j = 0; j < N; j++) begin
      tb_addr[j] = 28'($urandom);
      tb_data[j] = {$urandom, $urandom, $urandom, $urandom};
    end

    // Reset and idle behaviour: stray engine acks never reach a requester.
    for (int i = 0; i < 6; i++) begin
      rst = vt[i].rst;
      req = vt[i].req;
      tb_opt = vt[i].opt;
      ddr3_pg_ack = vt[i].pg_ack;
      ddr3_dpram_wren = vt[i].pg_wren;
      tick();
      chk("tbl_ack", ack, vt[i].e_ack);
      chk("tbl_wren", dpram_wren, vt[i].e_wren);
      chk("tbl_pg_req", ddr3_pg_req, vt[i].e_pg_req);
      chk("tbl_optype", ddr3_pg_optype, vt[i].e_opt);
      chk("tbl_grant", grant_idx, 2'd0);
      chk("tbl_addr", ddr3_pg_req_addr, tb_addr[0]);
      chk("tbl_timeout_err", timeout_err, 1'b0);
    end

    // Single hbuf request: ddr3_pg_req three cycles after req.
    do_reset();
    tb_opt = '0;
    req[0] = 1'b1;
    serve(0, 5, 0, 3'b000, n);
    chk("hbuf_latency", 128'(n), 3);

    // xdom read with four data beats.
    do_reset();
    tb_opt[1] = 1'b1;
    req[1] = 1'b1;
    serve(1, 2, 4, 3'b000, n);
    tick();
    chk("xdom_wren_idle", dpram_wren, 3'b000);

    // All three requesting continuously: order 0,1,2,0.
    do_reset();
    req = 3'b111;
    serve(0, 1, 1, 3'b000, n);
    req[0] = 1'b1;
    serve(1, 2, 0, 3'b000, n);
    req[1] = 1'b1;
    serve(2, 1, 2, 3'b000, n);
    req[2] = 1'b1;
    serve(0, 3, 0, 3'b000, n);
    do_reset();

    // Reset while in REQ drops the request; a stray ack afterwards is ignored.
    req[2] = 1'b1;
    wait_rise(n);
    chk("rst_pre_req", ddr3_pg_req, 1'b1);
    chk("rst_pre_grant", grant_idx, 2'd2);
    rst = 1'b1;
    req = '0;
    tick();
    chk("rst_pg_req", ddr3_pg_req, 1'b0);
    chk("rst_grant", grant_idx, 2'd0);
    rst = 1'b0;
    ddr3_pg_ack = 1'b1;
    #1;
    chk("rst_stray_ack", ack, 3'b000);
    repeat (4) begin
      tick();
      chk("rst_stray_ack_hold", ack, 3'b000);
      chk("rst_pg_req_low", ddr3_pg_req, 1'b0);
    end
    ddr3_pg_ack = 1'b0;

`ifdef DDR3_PG_ARB_TIMEOUT_EN
    // hbuf never releases: watchdog trips after 16 cycles in CLEAR.
    do_reset();
    req = 3'b001;
    wait_rise(n);
    chk("to_grant", grant_idx, 2'd0);
    ddr3_pg_ack = 1'b1;
    repeat (16) tick();
    chk("to_pg_req_before", ddr3_pg_req, 1'b1);
    chk("to_err_before", timeout_err, 1'b0);
    tick();
    chk("to_pg_req", ddr3_pg_req, 1'b0);
    chk("to_err", timeout_err, 1'b1);
    chk("to_idx", timeout_idx, 2'd0);
    ddr3_pg_ack = 1'b0;
    req[1] = 1'b1;
    serve(1, 1, 0, 3'b000, n);
    repeat (8) begin
      tick();
      chk("to_hbuf_masked", ddr3_pg_req, 1'b0);
    end
    req[0] = 1'b0;
    repeat (4) tick();
    req[0] = 1'b1;
    serve(0, 1, 0, 3'b000, n);
    chk("to_err_sticky", timeout_err, 1'b1);
`else
    // Without the watchdog a stuck requester simply holds the engine.
    do_reset();
    req = 3'b001;
    wait_rise(n);
    ddr3_pg_ack = 1'b1;
    repeat (40) tick();
    chk("hold_pg_req", ddr3_pg_req, 1'b1);
    chk("hold_no_err", timeout_err, 1'b0);
    req = '0;
    n = 0;
    while (ddr3_pg_req !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("hold_release", ddr3_pg_req, 1'b0);
    ddr3_pg_ack = 1'b0;
    tick();
`endif

    // Random traffic against the round-robin reference model.
    do_reset();
    pend = '0;
    last = N - 1;
    for (int j = 0; j < N; j++) waits[j] = 0;
    for (int t = 0; t < 150; t++) begin
      if (pend == 3'b000) begin
        raise = 3'($urandom_range(1, 7));
        req = req | raise;
        pend = pend | raise;
      end
      exp_g = rr_next(pend, last);
      chk("rr_wait_bound", 128'(waits[exp_g] <= N - 1), 1);
      raise = 3'($urandom_range(0, 7)) & ~pend;
      dly = int'($urandom_range(1, 4));
      nw = int'($urandom_range(0, 3));
      serve(exp_g, dly, nw, raise, n);
      for (int j = 0; j < N; j++) begin
        if (pend[j] && j != exp_g) waits[j]++;
      end
      waits[exp_g] = 0;
      pend = (pend & ~oh(exp_g)) | raise;
      last = exp_g;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
